// File: rtl/ramin_loader.sv
// ramin_loader: streams coefficient pairs into the NTT input RAM
// with a single modulo-q correction and a pass-through of read addresses.
module ramin_loader #(
   parameter int Q    = 3329,
   parameter int AWID = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_release,
   input  logic [31:0]     i_in_data,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [AWID-1:0] i_ntt_addr_a,
   input  logic [AWID-1:0] i_ntt_addr_b,
   output logic [AWID-1:0] o_ram_addr_a,
   output logic [AWID-1:0] o_ram_addr_b,
   output logic [15:0]     o_ram_din_a,
   output logic [15:0]     o_ram_din_b,
   output logic            o_ram_we1,
   output logic            o_ram_we2,
   output logic            o_full,
   output logic            o_done,
   output logic            o_err
);

   localparam int WW = AWID - 1;

   localparam logic [15:0] QV  = 16'(Q);
   localparam logic [15:0] Q2V = 16'(2 * Q);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic [1:0]      r_state;
   logic [WW-1:0]   r_wcnt;
   logic            r_we;
   logic [AWID-1:0] r_addr_a;
   logic [AWID-1:0] r_addr_b;
   logic [15:0]     r_din_a;
   logic [15:0]     r_din_b;
   logic            r_done;
   logic            r_err;

   logic            w_load;
   logic            w_accept;
   logic            w_wr;
   logic            w_last;
   logic [15:0]     w_lo;
   logic [15:0]     w_hi;
   logic [15:0]     w_red_lo;
   logic [15:0]     w_red_hi;
   logic            w_big;

   // Handshake decode and one-step modular correction of both halves
   always_comb begin
      w_load   = (r_state == S_LOAD);
      w_accept = w_load && i_in_valid;
      w_wr     = w_accept && !i_start;
      w_last   = (r_wcnt == {WW{1'b1}});
      w_lo     = i_in_data[15:0];
      w_hi     = i_in_data[31:16];
      w_red_lo = (w_lo >= QV) ? (w_lo - QV) : w_lo;
      w_red_hi = (w_hi >= QV) ? (w_hi - QV) : w_hi;
      w_big    = (w_lo >= Q2V) || (w_hi >= Q2V);
   end

   // Control FSM and word counter; start always re-arms from word 0
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LOAD;
                  r_wcnt  <= '0;
               end
            end
            S_LOAD: begin
               if (i_start) begin
                  r_wcnt <= '0;
               end else if (i_in_valid) begin
                  r_wcnt <= r_wcnt + 1'b1;
                  if (w_last) begin
                     r_state <= S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (i_start) begin
                  r_state <= S_LOAD;
                  r_wcnt  <= '0;
               end else if (i_release) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_wcnt  <= '0;
            end
         endcase
      end
   end

   // Write strobe: exactly one write cycle per accepted word
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_we <= 1'b0;
      end else begin
         r_we <= w_wr;
      end
   end

   // Write address/data capture; data holds when nothing is written
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_din_a  <= '0;
         r_din_b  <= '0;
      end else if (w_wr) begin
         r_addr_a <= {r_wcnt, 1'b0};
         r_addr_b <= {r_wcnt, 1'b1};
         r_din_a  <= w_red_lo;
         r_din_b  <= w_red_hi;
      end
   end

   // Completion pulse lines up with the final write cycle
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_wr && w_last;
      end
   end

   // Sticky out-of-range flag, cleared by a new start
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_err <= 1'b0;
      end else if (i_start) begin
         r_err <= 1'b0;
      end else if (w_wr && w_big) begin
         r_err <= 1'b1;
      end
   end

   // RAM port drive: write path while writing, consumer addresses otherwise
   always_comb begin
      o_ram_addr_a = r_we ? r_addr_a : i_ntt_addr_a;
      o_ram_addr_b = r_we ? r_addr_b : i_ntt_addr_b;
      o_ram_din_a  = r_din_a;
      o_ram_din_b  = r_din_b;
      o_ram_we1    = r_we;
      o_ram_we2    = r_we;
      o_in_ready   = w_load;
      o_full       = (r_state == S_FULL);
      o_done       = r_done;
      o_err        = r_err;
   end

endmodule

// File: tb/tb_ramin_loader.sv
// tb_ramin_loader: directed stimulus with a write scoreboard
// checked by an independent negedge monitor.
module tb_ramin_loader;

   typedef struct packed {
      logic [7:0]  aa;
      logic [7:0]  ab;
      logic [15:0] da;
      logic [15:0] db;
      logic        dn;
   } wr_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic        i_release;
   logic [31:0] i_in_data;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [7:0]  i_ntt_addr_a;
   logic [7:0]  i_ntt_addr_b;
   logic [7:0]  o_ram_addr_a;
   logic [7:0]  o_ram_addr_b;
   logic [15:0] o_ram_din_a;
   logic [15:0] o_ram_din_b;
   logic        o_ram_we1;
   logic        o_ram_we2;
   logic        o_full;
   logic        o_done;
   logic        o_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   wr_t  exp_q[$];
   logic [6:0] exp_wcnt = '0;

   always #5 clk = ~clk;

   ramin_loader #(.Q(3329), .AWID(8)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_release    (i_release),
      .i_in_data    (i_in_data),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_ntt_addr_a (i_ntt_addr_a),
      .i_ntt_addr_b (i_ntt_addr_b),
      .o_ram_addr_a (o_ram_addr_a),
      .o_ram_addr_b (o_ram_addr_b),
      .o_ram_din_a  (o_ram_din_a),
      .o_ram_din_b  (o_ram_din_b),
      .o_ram_we1    (o_ram_we1),
      .o_ram_we2    (o_ram_we2),
      .o_full       (o_full),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every write cycle pops one expected write
   always @(negedge clk) begin
      wr_t e;
      if (i_rst) begin
         if (o_ram_we1 || o_ram_we2) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr %0d at %0t",
                        o_ram_addr_a, $time);
            end else begin
               e = exp_q.pop_front();
               chk("we1", {31'd0, o_ram_we1}, 32'd1);
               chk("we2", {31'd0, o_ram_we2}, 32'd1);
               chk("addr_a", {24'd0, o_ram_addr_a}, {24'd0, e.aa});
               chk("addr_b", {24'd0, o_ram_addr_b}, {24'd0, e.ab});
               chk("din_a", {16'd0, o_ram_din_a}, {16'd0, e.da});
               chk("din_b", {16'd0, o_ram_din_b}, {16'd0, e.db});
               chk("done", {31'd0, o_done}, {31'd0, e.dn});
            end
         end else if (o_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_without_write: got 1 expected 0 at %0t", $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_in_valid = 1'b0;
      tick();
   endtask

   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start  = 1'b0;
      exp_wcnt = '0;
   endtask

   task automatic send(input logic [15:0] hi, input logic [15:0] lo,
                       input logic [15:0] ea, input logic [15:0] eb);
      wr_t e;
      i_in_valid = 1'b1;
      i_in_data  = {hi, lo};
      chk("in_ready", {31'd0, o_in_ready}, 32'd1);
      e.aa = {exp_wcnt, 1'b0};
      e.ab = {exp_wcnt, 1'b1};
      e.da = ea;
      e.db = eb;
      e.dn = (exp_wcnt == 7'd127);
      exp_q.push_back(e);
      exp_wcnt = exp_wcnt + 7'd1;
      tick();
   endtask

   task automatic stream(input int n, input int k0, input bit gap);
      for (int i = 0; i < n; i++) begin
         logic [15:0] lo;
         lo = 16'((k0 + i) * 2);
         send(lo + 16'd1, lo, lo, lo + 16'd1);
         if (gap) idle();
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd0);
      chk({tag, "_full"}, {31'd0, o_full}, 32'd0);
      chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
      chk({tag, "_we"}, {30'd0, o_ram_we1, o_ram_we2}, 32'd0);
      chk({tag, "_addr"}, {16'd0, o_ram_addr_a, o_ram_addr_b}, 32'd0);
      chk({tag, "_din"}, {o_ram_din_a, o_ram_din_b}, 32'd0);
   endtask

   initial begin
      i_rst        = 1'b0;
      i_start      = 1'b0;
      i_release    = 1'b0;
      i_in_data    = '0;
      i_in_valid   = 1'b0;
      i_ntt_addr_a = '0;
      i_ntt_addr_b = '0;
      #1;
      chk_outs_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b1;
      tick();

      // full load with {2k+1, 2k}
      do_start();
      stream(128, 0, 1'b0);
      i_in_valid = 1'b0;
      chk("load_full", {31'd0, o_full}, 32'd1);
      chk("load_ready", {31'd0, o_in_ready}, 32'd0);
      chk("load_err", {31'd0, o_err}, 32'd0);
      tick();

      // pass-through in FULL
      i_ntt_addr_a = 8'h5A;
      i_ntt_addr_b = 8'hA5;
      #1;
      chk("pt_addr_a", {24'd0, o_ram_addr_a}, 32'h5A);
      chk("pt_addr_b", {24'd0, o_ram_addr_b}, 32'hA5);
      chk("pt_we", {30'd0, o_ram_we1, o_ram_we2}, 32'd0);
      i_ntt_addr_a = '0;
      i_ntt_addr_b = '0;
      tick();

      // release alone: back to idle, valid ignored
      i_release = 1'b1;
      tick();
      i_release = 1'b0;
      chk("rel_full", {31'd0, o_full}, 32'd0);
      chk("rel_ready", {31'd0, o_in_ready}, 32'd0);
      i_in_valid = 1'b1;
      tick();
      tick();
      i_in_valid = 1'b0;
      chk("idle_ready", {31'd0, o_in_ready}, 32'd0);

      // reduction vectors
      do_start();
      send(16'd6657, 16'd3329, 16'd0, 16'd3328);
      idle();
      chk("red_err0", {31'd0, o_err}, 32'd0);
      send(16'd6658, 16'd0, 16'd0, 16'd3329);
      idle();
      chk("red_err1", {31'd0, o_err}, 32'd1);
      stream(126, 2, 1'b0);
      i_in_valid = 1'b0;
      chk("red_err_sticky", {31'd0, o_err}, 32'd1);
      chk("red_full", {31'd0, o_full}, 32'd1);
      tick();

      // release and start together: start wins
      i_release = 1'b1;
      i_start   = 1'b1;
      tick();
      i_release = 1'b0;
      i_start   = 1'b0;
      exp_wcnt  = '0;
      chk("rs_ready", {31'd0, o_in_ready}, 32'd1);
      chk("rs_full", {31'd0, o_full}, 32'd0);
      chk("rs_err", {31'd0, o_err}, 32'd0);

      // stalled load
      stream(128, 0, 1'b1);
      chk("stall_full", {31'd0, o_full}, 32'd1);

      // restart after 40 words with valid high
      do_start();
      stream(40, 0, 1'b0);
      i_start    = 1'b1;
      i_in_valid = 1'b1;
      i_in_data  = 32'h0000_7777;
      tick();
      i_start  = 1'b0;
      exp_wcnt = '0;
      stream(128, 0, 1'b0);
      i_in_valid = 1'b0;
      chk("rst_full", {31'd0, o_full}, 32'd1);
      tick();

      // asynchronous reset mid-load
      do_start();
      stream(60, 0, 1'b0);
      i_in_valid = 1'b0;
      void'(exp_q.pop_back());
      #2;
      i_rst = 1'b0;
      #1;
      chk_outs_zero("arst");
      @(posedge clk);
      #1;
      i_rst = 1'b1;
      tick();
      do_start();
      stream(128, 0, 1'b0);
      i_in_valid = 1'b0;
      chk("post_full", {31'd0, o_full}, 32'd1);
      chk("post_err", {31'd0, o_err}, 32'd0);
      repeat (3) tick();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
